// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and widths for the backend stall/flush controller.
// LREG_W and PC_W mirror the backend register-index and PC ranges.
package pipe_hazard_ctrl_pkg;

    localparam int LREG_W = 5;
    localparam int PC_W   = 32;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_RESP = 2'd2
    } mem_state_e;

    // True when an ID source is really read from the regfile and names rd.
    function automatic logic src_match(
        input logic              is_reg,
        input logic [LREG_W-1:0] rs,
        input logic [LREG_W-1:0] rd
    );
        return is_reg & (rs == rd);
    endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// MEM-stage request/response tracker; raises o_mem_hold while an access is open.
module mem_wait_fsm
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic i_req_valid,
    input  logic i_req_ready,
    input  logic i_resp_valid,
    output logic o_mem_hold
);

    mem_state_e r_state;
    mem_state_e w_state_nxt;

    // State register; reset abandons any outstanding access.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= MEM_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and hold. A response is only honoured from RESP, so an
    // access always spans at least a request cycle and a response cycle.
    always_comb begin
        w_state_nxt = r_state;
        o_mem_hold  = 1'b0;
        case (r_state)
            MEM_IDLE: begin
                if (i_req_valid) begin
                    o_mem_hold = 1'b1;
                    if (i_req_ready) begin
                        w_state_nxt = MEM_RESP;
                    end else begin
                        w_state_nxt = MEM_REQ;
                    end
                end else begin
                    w_state_nxt = MEM_IDLE;
                end
            end
            MEM_REQ: begin
                o_mem_hold = 1'b1;
                if (i_req_ready) begin
                    w_state_nxt = MEM_RESP;
                end else begin
                    w_state_nxt = MEM_REQ;
                end
            end
            MEM_RESP: begin
                if (i_resp_valid) begin
                    o_mem_hold  = 1'b0;
                    w_state_nxt = MEM_IDLE;
                end else begin
                    o_mem_hold  = 1'b1;
                    w_state_nxt = MEM_RESP;
                end
            end
            default: begin
                o_mem_hold  = 1'b0;
                w_state_nxt = MEM_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: load-use, mul/div occupancy, memory waits
// and EX branch redirects, resolved into per-pipeline-register hold/bubble.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MULDIV_LAT = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              id_instr_valid,
    input  logic [LREG_W-1:0] id_rs1,
    input  logic [LREG_W-1:0] id_rs2,
    input  logic              id_src1_is_reg,
    input  logic              id_src2_is_reg,
    input  logic              ex_instr_valid,
    input  logic [LREG_W-1:0] ex_rd,
    input  logic              ex_is_load,
    input  logic              ex_is_muldiv,
    input  logic              bju_redirect,
    input  logic [PC_W-1:0]   bju_target,
    input  logic              mem_req_valid,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    output logic              pc_stall,
    output logic              if2id_stall,
    output logic              id2ex_stall,
    output logic              ex2mem_stall,
    output logic              mem2wb_stall,
    output logic              if2id_flush,
    output logic              id2ex_flush,
    output logic              ex2mem_flush,
    output logic              mem2wb_flush,
    output logic              redirect_valid,
    output logic [PC_W-1:0]   redirect_target
);

    localparam int               CNT_W     = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
    localparam logic             MULDIV_EN = 1'(MULDIV_LAT > 1);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(MULDIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

    logic [CNT_W-1:0] r_cnt;
    logic             w_mem_hold;
    logic             w_start;
    logic             w_ex_hold;
    logic             w_load_use;
    logic             w_redirect;

    mem_wait_fsm u_mem_wait_fsm (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_req_valid  (mem_req_valid),
        .i_req_ready  (mem_req_ready),
        .i_resp_valid (mem_resp_valid),
        .o_mem_hold   (w_mem_hold)
    );

    assign w_start   = ex_instr_valid & ex_is_muldiv & (r_cnt == CNT_ZERO) & MULDIV_EN;
    assign w_ex_hold = w_start | (r_cnt > CNT_ONE);

    // Mul/div occupancy counter; frozen while MEM holds, since the older
    // instruction in MEM blocks EX from draining anyway.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= CNT_ZERO;
        end else if (w_mem_hold) begin
            r_cnt <= r_cnt;
        end else if (w_start) begin
            r_cnt <= CNT_LOAD;
        end else if (r_cnt != CNT_ZERO) begin
            r_cnt <= r_cnt - CNT_ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign w_load_use = id_instr_valid & ex_instr_valid & ex_is_load
                      & (ex_rd != {LREG_W{1'b0}})
                      & (src_match(id_src1_is_reg, id_rs1, ex_rd)
                       | src_match(id_src2_is_reg, id_rs2, ex_rd));

    // Redirect only on the cycle the branch actually leaves EX.
    assign w_redirect = ex_instr_valid & bju_redirect & ~w_ex_hold & ~w_mem_hold;

    assign pc_stall        = (w_mem_hold | w_ex_hold | w_load_use) & ~w_redirect;
    assign if2id_stall     = (w_mem_hold | w_ex_hold | w_load_use) & ~w_redirect;
    assign id2ex_stall     = w_mem_hold | w_ex_hold;
    assign ex2mem_stall    = w_mem_hold;
    assign mem2wb_stall    = 1'b0;
    assign if2id_flush     = w_redirect;
    assign id2ex_flush     = w_redirect | (w_load_use & ~w_mem_hold & ~w_ex_hold);
    assign ex2mem_flush    = w_ex_hold & ~w_mem_hold;
    assign mem2wb_flush    = w_mem_hold;
    assign redirect_valid  = w_redirect;
    assign redirect_target = bju_target;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl with MULDIV_LAT=4.
module tb_pipe_hazard_ctrl;

    logic        clock;
    logic        reset_n;
    logic        id_instr_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_src1_is_reg;
    logic        id_src2_is_reg;
    logic        ex_instr_valid;
    logic [4:0]  ex_rd;
    logic        ex_is_load;
    logic        ex_is_muldiv;
    logic        bju_redirect;
    logic [31:0] bju_target;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic        pc_stall, if2id_stall, id2ex_stall, ex2mem_stall, mem2wb_stall;
    logic        if2id_flush, id2ex_flush, ex2mem_flush, mem2wb_flush;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [9:0]  outs;

    int n_checks = 0;
    int n_fail   = 0;

    // {pc_st, if2id_st, id2ex_st, ex2mem_st, mem2wb_st, if2id_fl, id2ex_fl, ex2mem_fl, mem2wb_fl, redirect}
    localparam logic [9:0] P_IDLE  = 10'b00_0000_0000;
    localparam logic [9:0] P_LU    = 10'b11_0000_1000;
    localparam logic [9:0] P_EXH   = 10'b11_1000_0100;
    localparam logic [9:0] P_MEMH  = 10'b11_1100_0010;
    localparam logic [9:0] P_REDIR = 10'b00_0001_1001;

    assign outs = {pc_stall, if2id_stall, id2ex_stall, ex2mem_stall, mem2wb_stall,
                   if2id_flush, id2ex_flush, ex2mem_flush, mem2wb_flush, redirect_valid};

    pipe_hazard_ctrl #(.MULDIV_LAT(4)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .id_instr_valid  (id_instr_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_src1_is_reg  (id_src1_is_reg),
        .id_src2_is_reg  (id_src2_is_reg),
        .ex_instr_valid  (ex_instr_valid),
        .ex_rd           (ex_rd),
        .ex_is_load      (ex_is_load),
        .ex_is_muldiv    (ex_is_muldiv),
        .bju_redirect    (bju_redirect),
        .bju_target      (bju_target),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_resp_valid  (mem_resp_valid),
        .pc_stall        (pc_stall),
        .if2id_stall     (if2id_stall),
        .id2ex_stall     (id2ex_stall),
        .ex2mem_stall    (ex2mem_stall),
        .mem2wb_stall    (mem2wb_stall),
        .if2id_flush     (if2id_flush),
        .id2ex_flush     (id2ex_flush),
        .ex2mem_flush    (ex2mem_flush),
        .mem2wb_flush    (mem2wb_flush),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_inputs();
        id_instr_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        id_src1_is_reg = 1'b0; id_src2_is_reg = 1'b0;
        ex_instr_valid = 1'b0; ex_rd = 5'd0; ex_is_load = 1'b0; ex_is_muldiv = 1'b0;
        bju_redirect = 1'b0; bju_target = 32'd0;
        mem_req_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        clr_inputs();
        #2;
        check_val("reset_outs", 32'(outs), 32'(P_IDLE));
        check_val("reset_cnt", 32'(dut.r_cnt), 32'd0);
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // load x5 in EX, add x6,x5,x1 in ID
        ex_instr_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5;
        id_instr_valid = 1'b1; id_rs1 = 5'd5; id_rs2 = 5'd1;
        id_src1_is_reg = 1'b1; id_src2_is_reg = 1'b1;
        #1 check_val("lu_rs1", 32'(outs), 32'(P_LU));
        tick();
        ex_is_load = 1'b0; ex_rd = 5'd6;
        #1 check_val("lu_released", 32'(outs), 32'(P_IDLE));
        tick();
        ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
        #1 check_val("lu_x0", 32'(outs), 32'(P_IDLE));
        tick();
        ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; id_src2_is_reg = 1'b0;
        #1 check_val("lu_rs2_imm", 32'(outs), 32'(P_IDLE));
        id_src2_is_reg = 1'b1;
        #1 check_val("lu_rs2", 32'(outs), 32'(P_LU));
        bju_redirect = 1'b1;
        #1 check_val("redir_beats_lu", 32'(outs), 32'(P_REDIR));
        clr_inputs();
        tick();

        // mul occupancy, then a back-to-back second mul
        ex_instr_valid = 1'b1; ex_is_muldiv = 1'b1;
        #1 check_val("mul_start", 32'(outs), 32'(P_EXH));
        tick();
        #1 check_val("mul_c3", 32'(outs), 32'(P_EXH));
        check_val("mul_cnt3", 32'(dut.r_cnt), 32'd3);
        tick();
        #1 check_val("mul_c2", 32'(outs), 32'(P_EXH));
        check_val("mul_cnt2", 32'(dut.r_cnt), 32'd2);
        tick();
        #1 check_val("mul_release", 32'(outs), 32'(P_IDLE));
        check_val("mul_cnt1", 32'(dut.r_cnt), 32'd1);
        tick();
        #1 check_val("mul2_start", 32'(outs), 32'(P_EXH));
        clr_inputs();
        tick(); tick(); tick();
        #1 check_val("mul2_end", 32'(outs), 32'(P_IDLE));
        tick();
        #1 check_val("mul2_cnt0", 32'(dut.r_cnt), 32'd0);

        // load with ready low 2 cycles, response 3 cycles after acceptance
        mem_req_valid = 1'b1;
        #1 check_val("mem_m0", 32'(outs), 32'(P_MEMH));
        tick();
        mem_resp_valid = 1'b1;
        #1 check_val("mem_resp_in_req", 32'(outs), 32'(P_MEMH));
        tick();
        mem_resp_valid = 1'b0; mem_req_ready = 1'b1;
        #1 check_val("mem_m2", 32'(outs), 32'(P_MEMH));
        tick();
        mem_req_ready = 1'b0;
        #1 check_val("mem_m3", 32'(outs), 32'(P_MEMH));
        tick();
        #1 check_val("mem_m4", 32'(outs), 32'(P_MEMH));
        tick();
        mem_resp_valid = 1'b1;
        #1 check_val("mem_release", 32'(outs), 32'(P_IDLE));
        tick();
        clr_inputs();
        #1 check_val("mem_idle", 32'(outs), 32'(P_IDLE));

        // ready and response together in IDLE do not complete the access
        mem_req_valid = 1'b1; mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
        #1 check_val("mem_same_cycle", 32'(outs), 32'(P_MEMH));
        tick();
        mem_req_ready = 1'b0;
        #1 check_val("mem_min2", 32'(outs), 32'(P_IDLE));
        tick();
        clr_inputs();
        #1 check_val("mem_min2_idle", 32'(outs), 32'(P_IDLE));

        // mispredicted branch in EX while MEM waits
        ex_instr_valid = 1'b1; bju_redirect = 1'b1; bju_target = 32'h0000_1234;
        mem_req_valid = 1'b1; mem_req_ready = 1'b1;
        #1 check_val("br_memwait0", 32'(outs), 32'(P_MEMH));
        tick();
        mem_req_ready = 1'b0;
        #1 check_val("br_memwait1", 32'(outs), 32'(P_MEMH));
        tick();
        mem_resp_valid = 1'b1;
        #1 check_val("br_pulse", 32'(outs), 32'(P_REDIR));
        check_val("br_target", redirect_target, 32'h0000_1234);
        tick();
        clr_inputs();
        #1 check_val("br_single", 32'(outs), 32'(P_IDLE));

        // mul in EX while MEM waits: counter frozen before and during count
        ex_instr_valid = 1'b1; ex_is_muldiv = 1'b1; mem_req_valid = 1'b1;
        #1 check_val("mw_w0", 32'(outs), 32'(P_MEMH));
        tick();
        mem_req_ready = 1'b1;
        #1 check_val("mw_cnt_frozen0", 32'(dut.r_cnt), 32'd0);
        tick();
        mem_req_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b1;
        #1 check_val("mw_w2", 32'(outs), 32'(P_EXH));
        tick();
        mem_resp_valid = 1'b0; mem_req_valid = 1'b1; mem_req_ready = 1'b1;
        #1 check_val("mw_w3", 32'(outs), 32'(P_MEMH));
        tick();
        mem_req_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b1;
        #1 check_val("mw_cnt_frozen3", 32'(dut.r_cnt), 32'd3);
        check_val("mw_w4", 32'(outs), 32'(P_EXH));
        tick();
        mem_resp_valid = 1'b0;
        #1 check_val("mw_w5", 32'(outs), 32'(P_EXH));
        tick();
        #1 check_val("mw_release", 32'(outs), 32'(P_IDLE));
        check_val("mw_cnt1", 32'(dut.r_cnt), 32'd1);
        tick();
        clr_inputs();

        // reset during RESP with cnt=2
        ex_instr_valid = 1'b1; ex_is_muldiv = 1'b1;
        tick();
        clr_inputs();
        tick();
        mem_req_valid = 1'b1; mem_req_ready = 1'b1;
        tick();
        clr_inputs();
        #1 check_val("rst_pre_cnt", 32'(dut.r_cnt), 32'd2);
        check_val("rst_pre_outs", 32'(outs), 32'(P_MEMH));
        reset_n = 1'b0;
        #1 check_val("rst_async_outs", 32'(outs), 32'(P_IDLE));
        check_val("rst_async_cnt", 32'(dut.r_cnt), 32'd0);
        #1 reset_n = 1'b1;
        tick();
        #1 check_val("rst_after_outs", 32'(outs), 32'(P_IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the in-order backend. It drives the `stall` and `redirect_flush` inputs of every pipeline register instance:
- `if2id`, `id2ex`, `ex2mem` and `mem2wb` registers;
- the PC register stall.

It resolves four conditions: load-use hazards, multi-cycle mul/div occupancy of EX, memory request/response waits in MEM, and branch redirects from EX. It contains a memory-wait state machine and a mul/div occupancy counter.

## Interface
Parameters:
- MULDIV_LAT, 4, cycles a mul/div instruction occupies EX (>=1); 1 means no stall.

Ports:
- clock  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- id_instr_valid  input  1  ID-stage instruction valid
- id_rs1, id_rs2  input  `LREG_RANGE`  ID source registers
- id_src1_is_reg, id_src2_is_reg  input  1  source actually read from regfile
- ex_instr_valid  input  1  EX-stage instruction valid
- ex_rd  input  `LREG_RANGE`  EX destination
- ex_is_load  input  1  EX instruction is a load
- ex_is_muldiv  input  1  EX instruction has nonzero muldiv_type
- bju_redirect  input  1  EX branch mispredicted
- bju_target  input  `PC_RANGE`  corrected PC
- mem_req_valid  input  1  MEM-stage valid load/store needs memory
- mem_req_ready  input  1  memory accepts request
- mem_resp_valid  input  1  memory response/ack returned
- pc_stall, if2id_stall, id2ex_stall, ex2mem_stall, mem2wb_stall  output  1  per-register hold
- if2id_flush, id2ex_flush, ex2mem_flush, mem2wb_flush  output  1  per-register bubble (applies only when the matching stall is 0)
- redirect_valid  output  1  load PC with redirect_target this cycle
- redirect_target  output  `PC_RANGE`  equals bju_target

## Operation
Memory FSM, states IDLE, REQ and RESP:
- IDLE & mem_req_valid & ready -> RESP.
- IDLE & mem_req_valid & ~ready -> REQ.
- REQ & ready -> RESP.
- RESP & mem_resp_valid -> IDLE.
- mem_hold = (IDLE & mem_req_valid) | REQ | (RESP & ~mem_resp_valid).

Mul/div counter `cnt`, range 0..MULDIV_LAT-1:
- start = ex_instr_valid & ex_is_muldiv & cnt==0 & MULDIV_LAT>1.
- When start & ~mem_hold, cnt <= MULDIV_LAT-1.
- Otherwise, when cnt>0 & ~mem_hold, cnt decrements.
- When mem_hold, cnt is frozen.
- ex_hold = start | cnt>1.

Load-use detection:
- load_use = id_instr_valid & ex_instr_valid & ex_is_load & ex_rd!=0 & ((id_src1_is_reg & id_rs1==ex_rd) | (id_src2_is_reg & id_rs2==ex_rd)).

Redirect:
- redirect_valid = ex_instr_valid & bju_redirect & ~ex_hold & ~mem_hold.
- This fires exactly once per branch, on the cycle the branch leaves EX.

Outputs:
- pc_stall = if2id_stall = (mem_hold | ex_hold | load_use) & ~redirect_valid.
- id2ex_stall = mem_hold | ex_hold.
- ex2mem_stall = mem_hold.
- mem2wb_stall = 0.
- if2id_flush = redirect_valid.
- id2ex_flush = redirect_valid | (load_use & ~mem_hold & ~ex_hold).
- ex2mem_flush = ex_hold & ~mem_hold.
- mem2wb_flush = mem_hold.

Priority and simultaneous events:
- redirect beats load_use.
- mem_hold beats everything upstream.
- A redirect never aborts the memory FSM or the counter, because both belong to older instructions.

## Timing
- All outputs are combinational from state and inputs. Only the FSM and `cnt` are registered.
- Reset: FSM=IDLE, cnt=0. With all inputs 0, every output is 0.
- Reset mid-operation returns to IDLE/0 immediately. An outstanding memory transaction is abandoned.
- Load-use stall: 1 cycle, with a bubble inserted into ID/EX.
- Mul/div occupies EX for exactly MULDIV_LAT cycles when there is no mem_hold. The cycle with cnt==1 releases the instruction.
- Memory:
  - Minimum occupancy is 2 cycles (request, then response).
  - mem_req_ready and mem_resp_valid in the same cycle while in IDLE do not complete the access.
  - mem_resp_valid while in IDLE or REQ is ignored.
- Back-to-back mul/div: the second starts on the cycle after the first leaves. There is no dead cycle.

## Structure
- Shared package: MEM_FSM state encoding (IDLE=0, REQ=1, RESP=2).
- `LREG_RANGE` and `PC_RANGE` come from the existing defines.
- One natural sub-module: `mem_wait_fsm`, which owns the FSM and produces mem_hold. Counter and hazard logic stay in the top module.

## Test plan
- Load x5, then add x6,x5,x1 -> one cycle with pc_stall=if2id_stall=1, id2ex_flush=1, id2ex_stall=0. Repeat with rd=x0 -> no stall.
- mul in EX, MULDIV_LAT=4 -> id2ex_stall high for 3 cycles, cnt 3->2->1, ex2mem_flush high for 3 cycles, then releases.
- Load with mem_req_ready low for 2 cycles and response 3 cycles later -> mem_hold throughout, mem2wb_flush=1, ex2mem_stall=1, released on the response cycle.
- Mispredicted branch in EX while mem_hold=1 -> redirect_valid stays 0 until mem_hold drops, then a single-cycle pulse with if2id_flush=id2ex_flush=1 and pc_stall=0.
- mul in EX while MEM waits -> cnt frozen, total EX occupancy = MULDIV_LAT plus the mem wait cycles.
- reset_n low during RESP with cnt=2 -> all state cleared asynchronously, all outputs 0 with inputs 0.
